// File: rtl/mandelbrot_stream_gen_if.sv
// rtl/mandelbrot_stream_gen_if.sv - 32-bit video stream bundle with master/slave views
interface mandelbrot_stream_gen_if;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast;
    logic        tuser;
    logic        tvalid;
    logic        tready;

    modport master (output tdata, output tkeep, output tlast, output tuser, output tvalid,
                    input  tready);
    modport slave  (input  tdata, input  tkeep, input  tlast, input  tuser, input  tvalid,
                    output tready);
endinterface

// File: rtl/mandelbrot_stream_gen.sv
// rtl/mandelbrot_stream_gen.sv - multi-lane escape-time Mandelbrot pixel stream generator
module mandelbrot_stream_gen #(
    parameter int LANES  = 2,
    parameter int X_SIZE = 640,
    parameter int Y_SIZE = 480,
    parameter int DW     = 32,
    parameter int FRAC   = 8,
    parameter int ITER_W = 8
) (
    input  logic                     out_stream_aclk,
    input  logic                     periph_reset,
    input  logic signed [DW-1:0]     cfg_re0,
    input  logic signed [DW-1:0]     cfg_im0,
    input  logic signed [DW-1:0]     cfg_step_re,
    input  logic signed [DW-1:0]     cfg_step_im,
    input  logic [ITER_W-1:0]        cfg_max_iter,
    input  logic                     cfg_start,
    output logic                     busy,
    output logic                     frame_done,
    mandelbrot_stream_gen_if.master  out_stream
);
    localparam int TOTAL = X_SIZE * Y_SIZE;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int XW    = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
    localparam int YW    = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam logic signed [DW:0] ESC_LIM = (DW+1)'(4 << FRAC);

    typedef enum logic [1:0] {L_IDLE, L_ITER, L_DONE} lane_state_e;

    // Per-lane state
    lane_state_e              lane_st_q [LANES];
    logic signed [DW-1:0]     zr_q [LANES];
    logic signed [DW-1:0]     zi_q [LANES];
    logic signed [DW-1:0]     cre_q [LANES];
    logic signed [DW-1:0]     cim_q [LANES];
    logic [ITER_W-1:0]        n_q [LANES];
    logic                     esc_q [LANES];
    logic                     last_q [LANES];
    logic                     first_q [LANES];

    // Per-lane combinational iteration results
    logic signed [2*DW-1:0]   prr_c [LANES];
    logic signed [2*DW-1:0]   pii_c [LANES];
    logic signed [2*DW-1:0]   pri_c [LANES];
    logic signed [DW-1:0]     zr2_c [LANES];
    logic signed [DW-1:0]     zi2_c [LANES];
    logic signed [DW:0]       mag_c [LANES];
    logic signed [DW-1:0]     zr_n_c [LANES];
    logic signed [DW-1:0]     zi_n_c [LANES];
    logic                     esc_c [LANES];

    // Frame control, dispatcher and output stage state
    logic                     busy_q, frame_done_q;
    logic signed [DW-1:0]     re0_q, step_re_q, step_im_q;
    logic [ITER_W-1:0]        mi_q;
    logic signed [DW-1:0]     c_re_q, c_im_q;
    logic [XW-1:0]            dx_q;
    logic [YW-1:0]            dy_q;
    logic                     issue_all_q;
    logic [LW-1:0]            iss_ptr_q, out_ptr_q;
    logic [CW-1:0]            acc_cnt_q;
    logic                     tvalid_q, tlast_q, tuser_q;
    logic [31:0]              tdata_q;

    logic                     issue_v, cons_v, xfer;
    logic [7:0]               n8_c;
    logic [31:0]              colour_c;

    assign issue_v = busy_q && !issue_all_q && (lane_st_q[iss_ptr_q] == L_IDLE);
    assign cons_v  = busy_q && (lane_st_q[out_ptr_q] == L_DONE) && (!tvalid_q || out_stream.tready);
    assign xfer    = tvalid_q && out_stream.tready;

    assign n8_c     = 8'(n_q[out_ptr_q]);
    assign colour_c = esc_q[out_ptr_q] ? {8'h00, n8_c * 8'd30, n8_c * 8'd20, n8_c * 8'd10} : 32'h0;

    // One escape-time step per lane: squares, magnitude test and next z
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            prr_c[l]  = (2*DW)'(zr_q[l]) * (2*DW)'(zr_q[l]);
            pii_c[l]  = (2*DW)'(zi_q[l]) * (2*DW)'(zi_q[l]);
            pri_c[l]  = (2*DW)'(zr_q[l]) * (2*DW)'(zi_q[l]);
            zr2_c[l]  = DW'(prr_c[l] >>> FRAC);
            zi2_c[l]  = DW'(pii_c[l] >>> FRAC);
            mag_c[l]  = (DW+1)'(zr2_c[l]) + (DW+1)'(zi2_c[l]);
            esc_c[l]  = mag_c[l] > ESC_LIM;
            zr_n_c[l] = zr2_c[l] - zi2_c[l] + cre_q[l];
            zi_n_c[l] = DW'((pri_c[l] <<< 1) >>> FRAC) + cim_q[l];
        end
    end

    // Lane FSMs: load on issue, iterate, hold result until the output stage takes it
    always_ff @(posedge out_stream_aclk) begin
        if (periph_reset) begin
            for (int l = 0; l < LANES; l++) begin
                lane_st_q[l] <= L_IDLE;
                zr_q[l]      <= '0;
                zi_q[l]      <= '0;
                cre_q[l]     <= '0;
                cim_q[l]     <= '0;
                n_q[l]       <= '0;
                esc_q[l]     <= 1'b0;
                last_q[l]    <= 1'b0;
                first_q[l]   <= 1'b0;
            end
        end else begin
            for (int l = 0; l < LANES; l++) begin
                case (lane_st_q[l])
                    L_IDLE: begin
                        if (issue_v && iss_ptr_q == LW'(l)) begin
                            cre_q[l]     <= c_re_q;
                            cim_q[l]     <= c_im_q;
                            zr_q[l]      <= '0;
                            zi_q[l]      <= '0;
                            n_q[l]       <= '0;
                            last_q[l]    <= (dx_q == XW'(X_SIZE - 1));
                            first_q[l]   <= (dx_q == '0) && (dy_q == '0);
                            lane_st_q[l] <= L_ITER;
                        end
                    end
                    L_ITER: begin
                        if (esc_c[l]) begin
                            esc_q[l]     <= 1'b1;
                            lane_st_q[l] <= L_DONE;
                        end else begin
                            zr_q[l] <= zr_n_c[l];
                            zi_q[l] <= zi_n_c[l];
                            if ((n_q[l] + ITER_W'(1)) == mi_q) begin
                                esc_q[l]     <= 1'b0;
                                lane_st_q[l] <= L_DONE;
                            end else begin
                                n_q[l] <= n_q[l] + ITER_W'(1);
                            end
                        end
                    end
                    L_DONE: begin
                        if (cons_v && out_ptr_q == LW'(l))
                            lane_st_q[l] <= L_IDLE;
                    end
                    default: lane_st_q[l] <= L_IDLE;
                endcase
            end
        end
    end

    // Frame control, raster-order dispatcher and registered output beat
    always_ff @(posedge out_stream_aclk) begin
        if (periph_reset) begin
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            re0_q        <= '0;
            step_re_q    <= '0;
            step_im_q    <= '0;
            mi_q         <= '0;
            c_re_q       <= '0;
            c_im_q       <= '0;
            dx_q         <= '0;
            dy_q         <= '0;
            issue_all_q  <= 1'b0;
            iss_ptr_q    <= '0;
            out_ptr_q    <= '0;
            acc_cnt_q    <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            tuser_q      <= 1'b0;
            tdata_q      <= '0;
        end else begin
            frame_done_q <= 1'b0;

            if (cfg_start && !busy_q) begin
                busy_q      <= 1'b1;
                re0_q       <= cfg_re0;
                step_re_q   <= cfg_step_re;
                step_im_q   <= cfg_step_im;
                mi_q        <= (cfg_max_iter == '0) ? ITER_W'(1) : cfg_max_iter;
                c_re_q      <= cfg_re0;
                c_im_q      <= cfg_im0;
                dx_q        <= '0;
                dy_q        <= '0;
                issue_all_q <= 1'b0;
                iss_ptr_q   <= '0;
                out_ptr_q   <= '0;
                acc_cnt_q   <= '0;
            end

            if (issue_v) begin
                iss_ptr_q <= (iss_ptr_q == LW'(LANES - 1)) ? '0 : iss_ptr_q + LW'(1);
                if (dx_q == XW'(X_SIZE - 1)) begin
                    dx_q   <= '0;
                    c_re_q <= re0_q;
                    c_im_q <= c_im_q + step_im_q;
                    if (dy_q == YW'(Y_SIZE - 1))
                        issue_all_q <= 1'b1;
                    else
                        dy_q <= dy_q + YW'(1);
                end else begin
                    dx_q   <= dx_q + XW'(1);
                    c_re_q <= c_re_q + step_re_q;
                end
            end

            if (xfer) begin
                if (acc_cnt_q == CW'(TOTAL - 1)) begin
                    busy_q       <= 1'b0;
                    frame_done_q <= 1'b1;
                    acc_cnt_q    <= '0;
                end else begin
                    acc_cnt_q <= acc_cnt_q + CW'(1);
                end
            end

            if (cons_v) begin
                tvalid_q  <= 1'b1;
                tdata_q   <= colour_c;
                tlast_q   <= last_q[out_ptr_q];
                tuser_q   <= first_q[out_ptr_q];
                out_ptr_q <= (out_ptr_q == LW'(LANES - 1)) ? '0 : out_ptr_q + LW'(1);
            end else if (xfer) begin
                tvalid_q <= 1'b0;
            end
        end
    end

    assign busy              = busy_q;
    assign frame_done        = frame_done_q;
    assign out_stream.tvalid = tvalid_q;
    assign out_stream.tdata  = tdata_q;
    assign out_stream.tlast  = tlast_q;
    assign out_stream.tuser  = tuser_q;
    assign out_stream.tkeep  = 4'hF;
endmodule

// File: doc/mandelbrot_stream_gen.md
Name: mandelbrot_stream_gen

Overview:
- Parametrised successor to the two-engine fractal pixel generator. LANES independent fixed-point escape-time engines compute Mandelbrot pixels in parallel.
- Results are emitted in strict raster order on a 32-bit AXI4-Stream video output, with start-of-frame (tuser) and end-of-line (tlast) markers.
- Viewport origin, per-pixel step and iteration limit are run-time config inputs, driven by the AXI-Lite register file upstream. No divides are used for coordinate generation.

Parameters:
- LANES, 2, number of parallel iteration engines (1..8).
- X_SIZE, 640, pixels per line.
- Y_SIZE, 480, lines per frame.
- DW, 32, signed fixed-point datapath width.
- FRAC, 8, fractional bits (Q(DW-FRAC).FRAC); DW >= FRAC+12.
- ITER_W, 8, iteration counter width.

Ports:
- out_stream_aclk  in  1  single clock.
- periph_reset  in  1  synchronous, active-high reset.
- cfg_re0  in  DW  signed Re(c) of pixel (0,0).
- cfg_im0  in  DW  signed Im(c) of pixel (0,0).
- cfg_step_re  in  DW  signed Re increment per x.
- cfg_step_im  in  DW  signed Im increment per y.
- cfg_max_iter  in  ITER_W  iteration limit; 0 is treated as 1.
- cfg_start  in  1  one-cycle frame start request.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse after the last beat is accepted.
- out_stream_tdata  out  32  {8'h00, r, g, b}.
- out_stream_tkeep  out  4  constant 4'hF.
- out_stream_tlast  out  1  last pixel of a line.
- out_stream_tuser  out  1  first pixel of a frame.
- out_stream_tvalid  out  1  beat valid.
- out_stream_tready  in  1  sink ready.

Behaviour:
- Reset: busy=0, frame_done=0, tvalid=0, tlast=0, tuser=0, tdata=0. All lanes return to IDLE and the dispatcher clears. Applies on the next edge, including mid-frame and mid-beat; any partial frame is discarded.
- Start:
  - cfg_start with busy=0 latches all cfg_* inputs, sets busy on the next cycle, and zeroes the x/y counters.
  - cfg_start with busy=1 is ignored.
  - Config changes during a frame have no effect.
- Dispatcher:
  - Pixel index k (raster order) is issued to lane k mod LANES. A pixel is issued only when its lane is IDLE; at most one pixel is issued per cycle.
  - c_re is accumulated: re0 at x=0, +step_re per x.
  - c_im is accumulated: im0 at y=0, +step_im per line.
  - Each lane carries its own x==X_SIZE-1 flag and (0,0) flag.
- Lane FSM: IDLE -> ITER -> DONE -> IDLE.
  - IDLE: on issue, load c; set z=0, n=0.
  - ITER, one iteration per cycle:
    - zr2 = (zr*zr)>>>FRAC and zi2 = (zi*zi)>>>FRAC, using 2*DW products truncated to DW.
    - If zr2+zi2 > (4<<FRAC), go to DONE, escaped, count n.
    - Else if n+1 == max_iter, apply the update and go to DONE as interior.
    - Else update zr = zr2-zi2+c_re, zi = ((2*zr*zi)>>>FRAC)+c_im, and n = n+1.
  - DONE: hold the result until the output stage consumes it.
- Colour:
  - Interior pixels: 24'h000000.
  - Escaped pixels: r=(n*30)[7:0], g=(n*20)[7:0], b=(n*10)[7:0].
- Output stage:
  - Consumes lanes round-robin starting at lane 0, so a lane finishing early waits for earlier pixels and raster order is always preserved.
  - Registered tvalid. tdata/tlast/tuser are held stable while tvalid=1 and tready=0.
  - A beat transfers on tvalid&tready. The next beat may be presented in the same cycle if the next lane is DONE, giving 1 pixel/cycle peak.
  - tuser=1 only on pixel (0,0). tlast=1 on x=X_SIZE-1.
- End of frame:
  - After beat X_SIZE*Y_SIZE is accepted: frame_done=1 for exactly one cycle and busy=0 in the same cycle.
  - A new cfg_start is accepted from that cycle onward.
- Backpressure stalls only the output stage. Lanes keep iterating and then wait in DONE; no pixel is lost or duplicated.
- Latency: the first tvalid occurs within max_iter+4 cycles of the accepted cfg_start.

Test Plan:
- X_SIZE=4, Y_SIZE=2, LANES=2. Start with re0=im0=0, steps 0, max_iter=10 -> 8 beats of tdata 0x00000000, tuser on beat 1 only, tlast on beats 4 and 8, then one frame_done pulse with busy low.
- Same geometry with re0=512 (2.0), im0=0, steps 0 -> every beat is 0x003C2814 (n=2: check |z|^2=4 is not >4, then z=6 escapes).
- re0=0, step_re=512, max_iter=50: lane 0 is slow (interior) and lane 1 is fast (escape) -> output order is still x=0,1,2,3. Beats are 0x00000000, 0x003C2814, ... matching a golden model.
- Random tready with 30% duty over a full frame -> exactly X_SIZE*Y_SIZE beats, identical to the no-backpressure run, and tdata stable during every stall.
- cfg_start pulsed mid-frame -> ignored, frame completes unchanged.
- periph_reset asserted for 1 cycle at beat 3 -> tvalid=0 and busy=0 on the next cycle; a new start then produces a full correct frame beginning with tuser.
- LANES=1 and LANES=4 with cfg_max_iter=0 -> behaves as max_iter=1, all pixels escape-checked once, output identical across lane counts.
